// File: rtl/ob_pkg.sv
// ob_pkg: order-book table types shared by the table sequencer and its neighbours.
package ob_pkg;
    typedef logic [15:0] uid_t;
    typedef logic [15:0] quantity_t;
    typedef struct packed {
        uid_t        uid;
        quantity_t   qty;
        logic [15:0] price;
    } table_t;
    typedef enum logic [1:0] {ARB, DRAIN, DONE} ob_tbl_ctrl_state_t;
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/ob_tbl_ctrl_if.sv
// ob_tbl_ctrl_if: requester-side handshakes (head, insert, cancel, flush) of the table sequencer.
interface ob_tbl_ctrl_if;
    import ob_pkg::*;
    logic   hd_vld, hd_push, hd_rdy;
    table_t hd_push_tbl;
    logic   ins_vld, ins_rdy;
    table_t ins_tbl;
    logic   cxl_vld, cxl_rdy;
    uid_t   cxl_uid;
    logic   cxl_rsp_vld_r, cxl_rsp_hit_r;
    table_t cxl_rsp_tbl_r;
    logic   flush_req, flush_done_r, flush_side_r;
    modport master (
        output hd_vld, hd_push, hd_push_tbl, ins_vld, ins_tbl, cxl_vld, cxl_uid, flush_req,
        input  hd_rdy, ins_rdy, cxl_rdy, cxl_rsp_vld_r, cxl_rsp_hit_r, cxl_rsp_tbl_r,
               flush_done_r, flush_side_r
    );
    modport slave (
        input  hd_vld, hd_push, hd_push_tbl, ins_vld, ins_tbl, cxl_vld, cxl_uid, flush_req,
        output hd_rdy, ins_rdy, cxl_rdy, cxl_rsp_vld_r, cxl_rsp_hit_r, cxl_rsp_tbl_r,
               flush_done_r, flush_side_r
    );
endinterface

// File: rtl/ob_tbl_ctrl_arb.sv
// ob_tbl_ctrl_arb: head > cancel > insert fixed priority with an aged-insert override of cancel.
module ob_tbl_ctrl_arb (
    input  logic en,
    input  logic hd_vld,
    input  logic hd_push,
    input  logic head_vld,
    input  logic full,
    input  logic cxl_vld,
    input  logic ins_vld,
    input  logic age_hit,
    output logic hd_gnt,
    output logic cxl_gnt,
    output logic ins_gnt
);
    logic hd_ok, ins_ok, ins_force;
    always_comb begin
        hd_ok     = hd_vld && (hd_push ? !full : head_vld);
        ins_ok    = ins_vld && !full;
        ins_force = age_hit && ins_ok;
        hd_gnt    = en && hd_ok;
        cxl_gnt   = en && !hd_ok && cxl_vld && !ins_force;
        ins_gnt   = en && !hd_ok && ins_ok && (ins_force || !cxl_vld);
    end
endmodule

// File: rtl/ob_tbl_ctrl.sv
// ob_tbl_ctrl: single-port sequencer in front of one order table (arbitration, cancel response, flush).
// Define OB_TBL_CTRL_STATS_EN to add saturating activity counters.
module ob_tbl_ctrl
    import ob_pkg::*;
#(
    parameter int AGE_MAX = 8,
    parameter bit IS_ASK  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    ob_tbl_ctrl_if.slave req,
    output logic         tbl_head_pop,
    output logic         tbl_head_push,
    output table_t       tbl_head_push_tbl,
    output logic         tbl_insert,
    output table_t       tbl_insert_tbl,
    output logic         tbl_cancel,
    output uid_t         tbl_cancel_uid,
    input  logic         tbl_cancel_hit_w,
    input  table_t       tbl_cancel_hit_tbl_w,
    input  logic         tbl_full_w,
    input  logic         tbl_head_vld_r
`ifdef OB_TBL_CTRL_STATS_EN
    ,
    output logic [31:0]  stat_ins_r,
    output logic [31:0]  stat_cxl_hit_r,
    output logic [31:0]  stat_cxl_miss_r,
    output logic [31:0]  stat_hd_r
`endif
);
    ob_tbl_ctrl_state_t state_q, state_d;
    logic       full_q, rsp_vld_q, rsp_vld_d, rsp_hit_q, rsp_hit_d, done_q, done_d, side_q, side_d;
    logic [7:0] age_q, age_d;
    table_t     rsp_tbl_q, rsp_tbl_d;
    logic       hd_gnt, cxl_gnt, ins_gnt;

    ob_tbl_ctrl_arb u_arb (
        .en       (state_q == ARB),
        .hd_vld   (req.hd_vld),
        .hd_push  (req.hd_push),
        .head_vld (tbl_head_vld_r),
        .full     (full_q),
        .cxl_vld  (req.cxl_vld),
        .ins_vld  (req.ins_vld),
        .age_hit  (age_q == 8'(AGE_MAX)),
        .hd_gnt   (hd_gnt),
        .cxl_gnt  (cxl_gnt),
        .ins_gnt  (ins_gnt)
    );

    always_comb begin
        state_d   = state_q == ARB   ? ((req.flush_req && !(hd_gnt || cxl_gnt || ins_gnt)) ? DRAIN : ARB) :
                    state_q == DRAIN ? (tbl_head_vld_r ? DRAIN : DONE) : ARB;
        // age saturates at the threshold so the override stays armed until insert wins
        age_d     = ins_gnt ? 8'd0 :
                    (req.ins_vld && !full_q && age_q != 8'(AGE_MAX)) ? age_q + 8'd1 : age_q;
        rsp_vld_d = cxl_gnt;
        rsp_hit_d = cxl_gnt && tbl_cancel_hit_w;
        rsp_tbl_d = rsp_hit_d ? tbl_cancel_hit_tbl_w : '0;
        done_d    = state_d == DONE;
        side_d    = state_d == DONE && IS_ASK;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB;
            full_q    <= 1'b0;
            age_q     <= 8'd0;
            rsp_vld_q <= 1'b0;
            rsp_hit_q <= 1'b0;
            rsp_tbl_q <= '0;
            done_q    <= 1'b0;
            side_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= tbl_full_w;
            age_q     <= age_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_hit_q <= rsp_hit_d;
            rsp_tbl_q <= rsp_tbl_d;
            done_q    <= done_d;
            side_q    <= side_d;
        end
    end

    assign req.hd_rdy        = hd_gnt;
    assign req.cxl_rdy       = cxl_gnt;
    assign req.ins_rdy       = ins_gnt;
    assign req.cxl_rsp_vld_r = rsp_vld_q;
    assign req.cxl_rsp_hit_r = rsp_hit_q;
    assign req.cxl_rsp_tbl_r = rsp_tbl_q;
    assign req.flush_done_r  = done_q;
    assign req.flush_side_r  = side_q;
    assign tbl_head_pop      = (hd_gnt && !req.hd_push) || (state_q == DRAIN && tbl_head_vld_r);
    assign tbl_head_push     = hd_gnt && req.hd_push;
    assign tbl_head_push_tbl = tbl_head_push ? req.hd_push_tbl : '0;
    assign tbl_insert        = ins_gnt;
    assign tbl_insert_tbl    = ins_gnt ? req.ins_tbl : '0;
    assign tbl_cancel        = cxl_gnt;
    assign tbl_cancel_uid    = cxl_gnt ? req.cxl_uid : '0;

`ifdef OB_TBL_CTRL_STATS_EN
    logic [31:0] st_ins_q, st_ins_d, st_hit_q, st_hit_d, st_miss_q, st_miss_d, st_hd_q, st_hd_d;
    always_comb begin
        st_ins_d  = ins_gnt ? sat_inc32(st_ins_q) : st_ins_q;
        st_hit_d  = (cxl_gnt && tbl_cancel_hit_w) ? sat_inc32(st_hit_q) : st_hit_q;
        st_miss_d = (cxl_gnt && !tbl_cancel_hit_w) ? sat_inc32(st_miss_q) : st_miss_q;
        st_hd_d   = hd_gnt ? sat_inc32(st_hd_q) : st_hd_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_ins_q  <= '0;
            st_hit_q  <= '0;
            st_miss_q <= '0;
            st_hd_q   <= '0;
        end else begin
            st_ins_q  <= st_ins_d;
            st_hit_q  <= st_hit_d;
            st_miss_q <= st_miss_d;
            st_hd_q   <= st_hd_d;
        end
    end
    assign stat_ins_r      = st_ins_q;
    assign stat_cxl_hit_r  = st_hit_q;
    assign stat_cxl_miss_r = st_miss_q;
    assign stat_hd_r       = st_hd_q;
`endif
endmodule

// File: tb/tb_ob_tbl_ctrl.sv
// tb_ob_tbl_ctrl: directed bench for ob_tbl_ctrl with a small head-count model of the table.
module tb_ob_tbl_ctrl;
    import ob_pkg::*;
    localparam table_t HIT_E = '{uid: 16'd5, qty: 16'd100, price: 16'h0077};
    localparam table_t INS_E = '{uid: 16'd12, qty: 16'd30, price: 16'h0040};
    localparam table_t PSH_E = '{uid: 16'd21, qty: 16'd7, price: 16'h0123};

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   tbl_head_pop, tbl_head_push, tbl_insert, tbl_cancel;
    logic   tbl_cancel_hit_w, tbl_full_w, tbl_head_vld_r;
    table_t tbl_head_push_tbl, tbl_insert_tbl, tbl_cancel_hit_tbl_w;
    uid_t   tbl_cancel_uid;
    logic   cnt_load;
    int     cnt_val;
    int     cnt = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    logic [5:0] pops, dones, rdys;
    logic   seen;

    always #5 clk = ~clk;

    ob_tbl_ctrl_if bus ();

    ob_tbl_ctrl #(.AGE_MAX(8), .IS_ASK(1'b1)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req                  (bus),
        .tbl_head_pop         (tbl_head_pop),
        .tbl_head_push        (tbl_head_push),
        .tbl_head_push_tbl    (tbl_head_push_tbl),
        .tbl_insert           (tbl_insert),
        .tbl_insert_tbl       (tbl_insert_tbl),
        .tbl_cancel           (tbl_cancel),
        .tbl_cancel_uid       (tbl_cancel_uid),
        .tbl_cancel_hit_w     (tbl_cancel_hit_w),
        .tbl_cancel_hit_tbl_w (tbl_cancel_hit_tbl_w),
        .tbl_full_w           (tbl_full_w),
        .tbl_head_vld_r       (tbl_head_vld_r)
    );

    // table model: entry count popped from the head; only UID 5 is present for cancels
    always @(posedge clk) begin
        if (cnt_load) cnt <= cnt_val;
        else if (tbl_head_pop && cnt > 0) cnt <= cnt - 1;
    end
    assign tbl_head_vld_r       = cnt != 0;
    assign tbl_cancel_hit_w     = tbl_cancel && tbl_cancel_uid == 16'd5;
    assign tbl_cancel_hit_tbl_w = tbl_cancel_hit_w ? HIT_E : '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.hd_vld = 0; bus.hd_push = 0; bus.hd_push_tbl = '0;
        bus.ins_vld = 0; bus.ins_tbl = '0; bus.cxl_vld = 0; bus.cxl_uid = '0; bus.flush_req = 0;
        tbl_full_w = 0; cnt_load = 1; cnt_val = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_vld", 64'(bus.cxl_rsp_vld_r), 64'(0));
        chk("rst_rsp_tbl", 64'(bus.cxl_rsp_tbl_r), 64'(0));
        chk("rst_done", 64'(bus.flush_done_r), 64'(0));
        chk("rst_pop", 64'(tbl_head_pop), 64'(0));
        chk("rst_cancel", 64'(tbl_cancel), 64'(0));
        #2 rst = 1;
        cnt_val = 2;
        tick();
        cnt_load = 0;
        // all three requesters valid: head wins
        bus.hd_vld = 1; bus.cxl_vld = 1; bus.cxl_uid = 16'd5; bus.ins_vld = 1; bus.ins_tbl = INS_E;
        #1;
        chk("t1_hd_rdy", 64'(bus.hd_rdy), 64'(1));
        chk("t1_pop", 64'(tbl_head_pop), 64'(1));
        chk("t1_cxl_rdy", 64'(bus.cxl_rdy), 64'(0));
        chk("t1_ins_rdy", 64'(bus.ins_rdy), 64'(0));
        chk("t1_cancel_uid", 64'(tbl_cancel_uid), 64'(0));
        chk("t1_ins_tbl", 64'(tbl_insert_tbl), 64'(0));
        tick();
        bus.hd_vld = 0; bus.cxl_vld = 0;
        #1;
        chk("t1_ins_alone", 64'(bus.ins_rdy), 64'(1));
        chk("t1_ins_payload", 64'(tbl_insert_tbl), 64'(INS_E));
        tick();
        bus.ins_vld = 0;
        // cancel hit then miss
        bus.cxl_vld = 1; bus.cxl_uid = 16'd5;
        #1;
        chk("t2_cxl_rdy", 64'(bus.cxl_rdy), 64'(1));
        chk("t2_cancel", 64'(tbl_cancel), 64'(1));
        chk("t2_cancel_uid", 64'(tbl_cancel_uid), 64'(5));
        chk("t2_rsp_early", 64'(bus.cxl_rsp_vld_r), 64'(0));
        tick();
        chk("t2_hit_vld", 64'(bus.cxl_rsp_vld_r), 64'(1));
        chk("t2_hit", 64'(bus.cxl_rsp_hit_r), 64'(1));
        chk("t2_hit_tbl", 64'(bus.cxl_rsp_tbl_r), 64'(HIT_E));
        bus.cxl_uid = 16'd9;
        #1;
        chk("t2_miss_uid", 64'(tbl_cancel_uid), 64'(9));
        tick();
        chk("t2_miss_vld", 64'(bus.cxl_rsp_vld_r), 64'(1));
        chk("t2_miss_hit", 64'(bus.cxl_rsp_hit_r), 64'(0));
        chk("t2_miss_tbl", 64'(bus.cxl_rsp_tbl_r), 64'(0));
        bus.cxl_vld = 0;
        tick();
        chk("t2_rsp_one", 64'(bus.cxl_rsp_vld_r), 64'(0));
        // aging: cancel wins 8 times, insert the 9th, then cancel again
        bus.cxl_vld = 1; bus.cxl_uid = 16'd9; bus.ins_vld = 1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk($sformatf("t3_cxl_%0d", i), 64'(bus.cxl_rdy), 64'(i != 9));
            chk($sformatf("t3_ins_%0d", i), 64'(bus.ins_rdy), 64'(i == 9));
            @(posedge clk);
        end
        bus.cxl_vld = 0; bus.ins_vld = 0;
        #1;
        // full blocks insert and push but not pop
        tbl_full_w = 1;
        tick();
        bus.ins_vld = 1; bus.hd_vld = 1; bus.hd_push = 1; bus.hd_push_tbl = PSH_E;
        #1;
        chk("t4_ins_full", 64'(bus.ins_rdy), 64'(0));
        chk("t4_push_full", 64'(bus.hd_rdy), 64'(0));
        chk("t4_push_cmd", 64'(tbl_head_push), 64'(0));
        chk("t4_push_tbl0", 64'(tbl_head_push_tbl), 64'(0));
        bus.hd_push = 0;
        #1;
        chk("t4_pop_full", 64'(bus.hd_rdy), 64'(1));
        chk("t4_pop_cmd", 64'(tbl_head_pop), 64'(1));
        bus.hd_vld = 0; bus.ins_vld = 0; tbl_full_w = 0;
        tick();
        bus.hd_vld = 1; bus.hd_push = 1;
        #1;
        chk("t4_push_ok", 64'(bus.hd_rdy), 64'(1));
        chk("t4_push_tbl", 64'(tbl_head_push_tbl), 64'(PSH_E));
        bus.hd_vld = 0; bus.hd_push = 0;
        // flush of three entries; request dropped once draining
        cnt_load = 1; cnt_val = 3;
        tick();
        cnt_load = 0;
        bus.flush_req = 1;
        tick();
        for (int k = 0; k < 6; k++) begin
            pops[k] = tbl_head_pop;
            dones[k] = bus.flush_done_r;
            rdys[k] = bus.ins_rdy;
            if (k == 4) chk("t5_side", 64'(bus.flush_side_r), 64'(1));
            if (k == 0) begin
                bus.flush_req = 0;
                bus.ins_vld = 1;
            end
            tick();
        end
        bus.ins_vld = 0;
        chk("t5_pops", 64'(pops), 64'(6'b000111));
        chk("t5_done", 64'(dones), 64'(6'b010000));
        chk("t5_ins_rdy", 64'(rdys), 64'(6'b100000));
        chk("t5_empty", 64'(cnt), 64'(0));
        // reset during drain
        cnt_load = 1; cnt_val = 4;
        tick();
        cnt_load = 0;
        bus.flush_req = 1;
        tick();
        chk("t6_draining", 64'(tbl_head_pop), 64'(1));
        #2 rst = 0;
        #1;
        chk("t6_pop_rst", 64'(tbl_head_pop), 64'(0));
        chk("t6_done_rst", 64'(bus.flush_done_r), 64'(0));
        bus.flush_req = 0;
        tick();
        rst = 1;
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            seen = seen | tbl_head_pop | bus.flush_done_r;
            tick();
        end
        chk("t6_no_done", 64'(seen), 64'(0));
        chk("t6_cnt_kept", 64'(cnt), 64'(4));
        bus.ins_vld = 1;
        #1;
        chk("t6_arb", 64'(bus.ins_rdy), 64'(1));
        bus.ins_vld = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
